// File: rtl/pio_read_arbiter.sv
// Two-requester read arbiter in front of a single registered PIO slave.
// Define PIO_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
module pio_read_arbiter #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic              ack0,
  output logic              ack1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] pio_address,
  input  logic [DATA_W-1:0] pio_readdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              win_q, win_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              rv0_q, rv0_d;
  logic              rv1_q, rv1_d;
  logic [DATA_W-1:0] rd0_q, rd0_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic              grant1;

`ifdef PIO_ARB_FIXED_PRIO_EN
  assign grant1 = req1 & ~req0;
`else
  logic last_q, last_d;

  // On a tie, requester 1 wins only if requester 0 was served last
  assign grant1 = req1 & (~req0 | ~last_q);
`endif

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    addr_d  = addr_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    rv0_d   = 1'b0;
    rv1_d   = 1'b0;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
`ifndef PIO_ARB_FIXED_PRIO_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          win_d   = grant1;
          addr_d  = grant1 ? addr1 : addr0;
          ack0_d  = ~grant1;
          ack1_d  = grant1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        if (win_q) begin
          rd1_d = pio_readdata;
          rv1_d = 1'b1;
        end else begin
          rd0_d = pio_readdata;
          rv0_d = 1'b1;
        end
`ifndef PIO_ARB_FIXED_PRIO_EN
        last_d  = win_q;
`endif
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      win_q   <= 1'b0;
      addr_q  <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
`ifndef PIO_ARB_FIXED_PRIO_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      addr_q  <= addr_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
`ifndef PIO_ARB_FIXED_PRIO_EN
      last_q  <= last_d;
`endif
    end
  end

  assign ack0        = ack0_q;
  assign ack1        = ack1_q;
  assign rvalid0     = rv0_q;
  assign rvalid1     = rv1_q;
  assign rdata0      = rd0_q;
  assign rdata1      = rd1_q;
  assign pio_address = addr_q;

endmodule

// File: tb/tb_pio_read_arbiter.sv
// Bench for pio_read_arbiter: directed scenarios plus random traffic
// checked against a transaction-timestamp reference model.
module tb_pio_read_arbiter;

  localparam int AW = 2;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req0 = 1'b0;
  logic          req1 = 1'b0;
  logic          in_port = 1'b0;
  logic [AW-1:0] addr0 = '0;
  logic [AW-1:0] addr1 = '0;
  logic          ack0, ack1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] pio_address;
  logic [DW-1:0] pio_readdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pio_read_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req0(req0),
    .req1(req1),
    .addr0(addr0),
    .addr1(addr1),
    .ack0(ack0),
    .ack1(ack1),
    .rvalid0(rvalid0),
    .rvalid1(rvalid1),
    .rdata0(rdata0),
    .rdata1(rdata1),
    .pio_address(pio_address),
    .pio_readdata(pio_readdata)
  );

  // PIO slave: registered readdata, only address 0 is mapped
  always @(posedge clk)
    pio_readdata <= (pio_address == 0) ? {{(DW-1){1'b0}}, in_port} : '0;

  // Reference model: a transaction granted at cycle g reads the slave
  // at g+1, delivers at g+2, and the arbiter is free again at g+3.
  int            cyc = 0;
  bit            m_busy, m_win, m_last;
  int            m_gcyc;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data, m_rd0, m_rd1;
  bit            m_ack0, m_ack1, m_rv0, m_rv1;

  always @(posedge clk) begin
    cyc++;
    m_ack0 = 0; m_ack1 = 0; m_rv0 = 0; m_rv1 = 0;
    if (!reset_n) begin
      m_busy = 0; m_last = 1; m_addr = '0;
      m_rd0 = '0; m_rd1 = '0;
    end else if (m_busy && cyc == m_gcyc + 1) begin
      m_data = (m_addr == 0) ? {{(DW-1){1'b0}}, in_port} : '0;
    end else if (m_busy && cyc == m_gcyc + 2) begin
      if (m_win) begin m_rd1 = m_data; m_rv1 = 1; end
      else begin m_rd0 = m_data; m_rv0 = 1; end
      m_last = m_win;
      m_busy = 0;
    end else if (!m_busy && (req0 || req1)) begin
`ifdef PIO_ARB_FIXED_PRIO_EN
      m_win = !req0;
`else
      m_win = (req0 && req1) ? !m_last : req1;
`endif
      m_addr = m_win ? addr1 : addr0;
      if (m_win) m_ack1 = 1; else m_ack0 = 1;
      m_busy = 1;
      m_gcyc = cyc;
    end
  end

  task automatic test_reset();
    reset_n = 0; req0 = 0; req1 = 0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({ack0, ack1, rvalid0, rvalid1} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_pulses got %b want 0000", {ack0, ack1, rvalid0, rvalid1});
    end
    vectors++;
    if (pio_address !== '0) begin
      miscompares++;
      $display("FAIL reset_addr got %0h want 0", pio_address);
    end
    vectors++;
    if (rdata0 !== '0 || rdata1 !== '0) begin
      miscompares++;
      $display("FAIL reset_rdata got %0h/%0h want 0/0", rdata0, rdata1);
    end
    reset_n = 1;
  endtask

  task automatic test_single_read();
    in_port = 1; req0 = 1; addr0 = 0;
    @(negedge clk);
    req0 = 0;
    vectors++;
    if ({ack0, ack1} !== 2'b10) begin
      miscompares++;
      $display("FAIL single_ack got %b want 10", {ack0, ack1});
    end
    @(negedge clk);
    vectors++;
    if ({ack0, rvalid0} !== 2'b00) begin
      miscompares++;
      $display("FAIL single_issue got %b want 00", {ack0, rvalid0});
    end
    @(negedge clk);
    vectors++;
    if ({rvalid0, rvalid1} !== 2'b10) begin
      miscompares++;
      $display("FAIL single_rvalid got %b want 10", {rvalid0, rvalid1});
    end
    vectors++;
    if (rdata0 !== 32'h1 || rdata1 !== 32'h0) begin
      miscompares++;
      $display("FAIL single_rdata got %0h/%0h want 1/0", rdata0, rdata1);
    end
  endtask

  task automatic test_round_robin();
    bit seen_rv1 = 0;
    bit exp_w;
    int w;
    reset_n = 0;
    @(negedge clk);
    reset_n = 1;
    req0 = 1; req1 = 1; addr0 = 0; addr1 = 1; in_port = 1;
    for (int g = 0; g < 4; g++) begin
      w = 0;
      do begin
        @(negedge clk);
        w++;
        seen_rv1 |= rvalid1;
      end while (!(ack0 | ack1) && w < 10);
`ifdef PIO_ARB_FIXED_PRIO_EN
      exp_w = 0;
`else
      exp_w = g[0];
`endif
      vectors++;
      if ({ack0, ack1} !== (exp_w ? 2'b01 : 2'b10) || w != (g == 0 ? 1 : 3)) begin
        miscompares++;
        $display("FAIL tie_grant%0d got ack %b after %0d cycles want winner %0d",
                 g, {ack0, ack1}, w, exp_w);
      end
    end
    req0 = 0; req1 = 0;
    repeat (3) begin
      @(negedge clk);
      seen_rv1 |= rvalid1;
    end
    vectors++;
`ifdef PIO_ARB_FIXED_PRIO_EN
    if (seen_rv1 !== 1'b0) begin
`else
    if (seen_rv1 !== 1'b1) begin
`endif
      miscompares++;
      $display("FAIL tie_rvalid1 got seen=%0d", seen_rv1);
    end
    vectors++;
    if (rdata0 !== 32'h1 || rdata1 !== 32'h0) begin
      miscompares++;
      $display("FAIL tie_rdata got %0h/%0h want 1/0", rdata0, rdata1);
    end
  endtask

  task automatic test_mid_reset();
    req0 = 1; addr0 = 0; in_port = 1;
    @(negedge clk);
    req0 = 0;
    @(negedge clk);
    reset_n = 0;
    @(negedge clk);
    vectors++;
    if ({ack0, ack1, rvalid0, rvalid1} !== 4'b0 || pio_address !== '0 ||
        rdata0 !== '0 || rdata1 !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs got %b a=%0h d=%0h/%0h want all 0",
               {ack0, ack1, rvalid0, rvalid1}, pio_address, rdata0, rdata1);
    end
    reset_n = 1; req1 = 1; addr1 = 1;
    @(negedge clk);
    req1 = 0;
    vectors++;
    if ({ack0, ack1} !== 2'b01 || pio_address !== 2'd1) begin
      miscompares++;
      $display("FAIL midreset_ack1 got %b a=%0h want 01 a=1", {ack0, ack1}, pio_address);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_withdrawn();
    bit bad = 0;
    bit got0 = 0;
    req0 = 1; addr0 = 0;
    @(negedge clk);
    req0 = 0; req1 = 1; addr1 = 2;
    @(negedge clk);
    req1 = 0;
    repeat (6) begin
      bad  |= ack1 | rvalid1;
      got0 |= rvalid0;
      @(negedge clk);
    end
    vectors++;
    if (bad !== 1'b0 || got0 !== 1'b1) begin
      miscompares++;
      $display("FAIL withdrawn got req1_activity=%0d rvalid0=%0d want 0/1", bad, got0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      vectors++;
      if ({ack0, ack1, rvalid0, rvalid1} !== {m_ack0, m_ack1, m_rv0, m_rv1}) begin
        miscompares++;
        $display("FAIL rand_pulses cyc %0d got %b want %b", cyc,
                 {ack0, ack1, rvalid0, rvalid1}, {m_ack0, m_ack1, m_rv0, m_rv1});
      end
      vectors++;
      if (pio_address !== m_addr || rdata0 !== m_rd0 || rdata1 !== m_rd1) begin
        miscompares++;
        $display("FAIL rand_data cyc %0d got a=%0h d=%0h/%0h want a=%0h d=%0h/%0h",
                 cyc, pio_address, rdata0, rdata1, m_addr, m_rd0, m_rd1);
      end
      vectors++;
      if ((ack0 & ack1) | (rvalid0 & rvalid1)) begin
        miscompares++;
        $display("FAIL rand_exclusive cyc %0d got %b want no pair",
                 cyc, {ack0, ack1, rvalid0, rvalid1});
      end
      reset_n = ($urandom_range(0, 99) != 0);
      req0    = $urandom_range(0, 1);
      req1    = $urandom_range(0, 1);
      addr0   = AW'($urandom);
      addr1   = AW'($urandom);
      in_port = $urandom_range(0, 1);
    end
    reset_n = 1; req0 = 0; req1 = 0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_mid_reset();
    test_withdrawn();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pio_read_arbiter.md
PIO_READ_ARBITER -- requirements
Module: pio_read_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 2, PIO slave address width.
REQ-002 SHALL have parameter DATA_W, default 32, PIO readdata width.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have ports req0/req1  input  1  per-requester read request, level.
REQ-006 SHALL have ports addr0/addr1  input  ADDR_W  per-requester PIO register address.
REQ-007 SHALL have ports ack0/ack1  output  1  one-cycle pulse: request accepted, address captured.
REQ-008 SHALL have ports rvalid0/rvalid1  output  1  one-cycle pulse: rdata0/rdata1 valid.
REQ-009 SHALL have ports rdata0/rdata1  output  DATA_W  read result, held until that requester's next rvalid.
REQ-010 SHALL have port pio_address  output  ADDR_W  registered address to the shared PIO slave.
REQ-011 SHALL have port pio_readdata  input  DATA_W  PIO readdata, registered in the slave one clock after the address.

Function
REQ-012 SHALL implement FSM IDLE -> ISSUE -> CAPTURE -> IDLE; ISSUE and CAPTURE unconditional, one cycle each.
REQ-013 In IDLE with any req high, SHALL select a winner, register pio_address from the winner's addr, pulse that ack, and enter ISSUE.
REQ-014 In IDLE with no req, SHALL stay in IDLE and hold pio_address.
REQ-015 In ISSUE, SHALL hold pio_address; the slave samples it at this edge.
REQ-016 In CAPTURE, SHALL register pio_readdata into the winner's rdata, pulse its rvalid, update last_grant, and return to IDLE.
REQ-017 Latency: req sampled high at edge E -> ack visible after E, rvalid/rdata visible after E+2.
REQ-018 Throughput: at most one read per 3 cycles; the next grant is evaluated in the cycle rvalid is high.
REQ-019 Requester SHALL hold req/addr stable until ack; req still high after ack SHALL count as a new request.
REQ-020 req dropped before ack SHALL produce no transaction.
REQ-021 Simultaneous req0 and req1 (round-robin) SHALL grant the requester other than last_grant.
REQ-022 A single active requester SHALL be granted regardless of last_grant.
REQ-023 ack0 and ack1 SHALL never both be high; likewise rvalid0 and rvalid1.
REQ-024 The non-winning rdata SHALL be unchanged by a transaction.

Reset
REQ-025 With reset_n low at a clk edge: state=IDLE, pio_address=0, ack*=0, rvalid*=0, rdata*=0, last_grant=1, so requester 0 wins the first tie.
REQ-026 Reset mid-transaction SHALL abort the read with no rvalid; operation resumes from IDLE on the first edge with reset_n high.

Configuration
REQ-027 Macro PIO_ARB_FIXED_PRIO_EN defined: requester 0 SHALL always win ties; last_grant is unused.
REQ-028 Macro PIO_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-021. All other behaviour SHALL be identical.

Verification
REQ-029 The bench SHALL model the PIO slave as readdata <= (address==0) ? {31'b0,in_port} : 0, registered.
REQ-030 Single read: in_port=1, req0=1, addr0=0 for one cycle -> ack0 next cycle; rvalid0 two cycles later with rdata0=32'h00000001; rdata1 stays 0.
REQ-031 Tie, round-robin: req0=req1=1 held, addr0=0, addr1=1, in_port=1 -> grant order 0,1,0,1 every 3 cycles; rdata0=1, rdata1=0.
REQ-032 Tie with PIO_ARB_FIXED_PRIO_EN: req0=req1=1 held -> only requester 0 is acked; rvalid1 never asserts.
REQ-033 Mid-operation reset: reset_n=0 during CAPTURE -> no rvalid that cycle; all outputs 0 next cycle; a later req1 is acked within 1 cycle of its request.
REQ-034 Withdrawn request: req1 high for one cycle while a req0 transaction is in ISSUE -> no ack1 and no rvalid1.
